if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS datapath. It owns the program counter and drives the instruction-memory address. It captures the returned word into the IF/ID pipeline register, along with PC+4 and a valid bit. It also handles stall, branch/jump redirect, flush, a start gate and halt detection.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_INSTR, 32'hFFFF_FFFF, fetched word that stops the fetch unit
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  leave IDLE and begin fetching (level or pulse)
- Stall  in  1  hazard unit: hold PC and IF/ID contents
- Flush  in  1  squash the IF/ID contents (bubble)
- BranchTaken  in  1  redirect to BranchTarget
- BranchTarget  in  32  branch destination
- Jump  in  1  redirect to JumpTarget (priority over BranchTaken)
- JumpTarget  in  32  jump destination
- Instruction  in  32  combinational read data from instruction memory
- InstrAddress  out  32  current PC, to instruction-memory address port
- IfId_Instruction  out  32  registered instruction
- IfId_PCPlus4  out  32  registered PC+4 of that instruction
- IfId_Valid  out  1  IF/ID holds a real instruction
- FetchCount  out  32  number of instructions committed into IF/ID
- Halted  out  1  fetch unit is in HALT

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - HALT
- IDLE:
  - PC held at RESET_PC; IF/ID bubble.
  - Start=1 moves to RUN at the next edge; no capture on that edge.
- RUN, evaluated each edge in the priority order below.
  - Redirect (Jump|BranchTaken):
    - PC <= target with bits[1:0] forced to 0.
    - Target is Jump ? JumpTarget : BranchTarget.
    - IF/ID <= bubble. FetchCount unchanged.
    - Stall is ignored in this case.
  - Flush alone:
    - PC <= PC+4; IF/ID <= bubble.
    - FetchCount unchanged.
  - Stall:
    - PC, IF/ID and FetchCount hold.
  - Instruction == HALT_INSTR:
    - Move to HALT; PC holds; IF/ID <= bubble.
    - The halt word is never passed downstream.
  - Otherwise (normal fetch):
    - IfId_Instruction <= Instruction; IfId_PCPlus4 <= PC+4; IfId_Valid <= 1.
    - PC <= PC+4; FetchCount <= FetchCount+1.
- HALT:
  - PC frozen; IF/ID bubble; Halted=1.
  - All inputs except Rst_n are ignored; the only exit is reset.
- Bubble means IfId_Instruction=0 (MIPS nop), IfId_PCPlus4=0, IfId_Valid=0.
- Arithmetic:
  - PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no error.
  - FetchCount wraps modulo 2^32.
  - Memory indexes with address bits [11:2], so the PC wraps within the 1024-word image.
- InstrAddress = PC register directly; no combinational path from redirect inputs to InstrAddress.

## Timing
- Reset (async, Rst_n=0) sets all of the following immediately:
  - PC=RESET_PC, InstrAddress=RESET_PC, state IDLE.
  - IfId_Instruction=0, IfId_PCPlus4=0, IfId_Valid=0.
  - FetchCount=0, Halted=0.
- Reset asserted mid-RUN or mid-HALT aborts at once. Deassertion is sampled synchronously, so the first active edge is the one after Rst_n rises.
- Latency: when PC=A in RUN with no stall or redirect, the word at A appears on IfId_Instruction after one edge, with IfId_PCPlus4=A+4.
- Redirect taken at edge N:
  - InstrAddress=target after edge N.
  - The target instruction is valid in IF/ID after edge N+1.
  - Penalty: one bubble.
- Stall is combinational-enable only. Back-to-back stall cycles hold state indefinitely with no lost instruction.
- Halted rises the edge after the halt word is presented while in RUN and not stalled.

## Test plan
- Reset then Start=1 with memory[i]=i*3:
  - First RUN edge: IfId_Instruction=0, IfId_PCPlus4=4, Valid=1.
  - Next edge: Instruction=3, PCPlus4=8.
  - FetchCount=2.
- Stall held 3 cycles at PC=8:
  - InstrAddress stays 8; IF/ID unchanged; FetchCount unchanged.
  - On release, word 6 is captured.
- BranchTaken=1, BranchTarget=32'h43 with Stall=1 at the same edge:
  - InstrAddress=32'h40; Valid=0 that cycle.
  - Next edge: IfId_Instruction=memory[16]=48, PCPlus4=32'h44.
- Jump and BranchTaken both asserted, JumpTarget=32'h100, BranchTarget=32'h20:
  - InstrAddress=32'h100.
- memory[5]=32'hFFFF_FFFF with a sequential run:
  - After word 4 is captured, Halted=1, PC frozen at 20, Valid=0.
  - A later Jump has no effect.
- Rst_n pulled low mid-RUN (async, between edges):
  - Outputs return to reset values without a clock edge.
  - State IDLE; InstrAddress=RESET_PC; FetchCount=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID pipeline register. Supports stall, redirect (jump/branch),
// flush, a start gate out of IDLE and a terminal HALT on the halt word.
//
// Handshake note: there is no valid/ready pair on this block. stall_i is a
// plain hold-enable from the hazard unit, and ifid_valid_o marks a real
// instruction in IF/ID (0 = bubble, meaning instruction 0 and PC+4 0).
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] instruction_i,
    output logic [31:0] instr_address_o,
    output logic [31:0] ifid_instruction_o,
    output logic [31:0] ifid_pcplus4_o,
    output logic        ifid_valid_o,
    output logic [31:0] fetch_count_o,
    output logic        halted_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pcp4_q;
    logic        ifid_valid_q;
    logic [31:0] fetch_cnt_q;
    logic        halted_q;

    logic [31:0] pc_inc_d;
    logic        redirect_d;
    logic [31:0] redirect_pc_d;
    logic        is_halt_word_d;

    // Sequential PC, redirect target (jump wins, word aligned) and halt decode.
    always_comb begin
        pc_inc_d       = pc_q + 32'd4;
        redirect_d     = jump_i | branch_taken_i;
        redirect_pc_d  = (jump_i ? jump_target_i : branch_target_i) & ~32'd3;
        is_halt_word_d = (instruction_i == HALT_INSTR);
    end

    // Fetch FSM: PC, IF/ID register, fetch counter and halt flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'd0;
            ifid_pcp4_q  <= 32'd0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'd0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Start only opens the gate; the first capture is one edge later.
                    pc_q         <= RESET_PC;
                    ifid_instr_q <= 32'd0;
                    ifid_pcp4_q  <= 32'd0;
                    ifid_valid_q <= 1'b0;
                    if (start_i) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (redirect_d) begin
                        // Redirect overrides a stall: the wrong-path word is dropped.
                        pc_q         <= redirect_pc_d;
                        ifid_instr_q <= 32'd0;
                        ifid_pcp4_q  <= 32'd0;
                        ifid_valid_q <= 1'b0;
                    end else if (flush_i) begin
                        pc_q         <= pc_inc_d;
                        ifid_instr_q <= 32'd0;
                        ifid_pcp4_q  <= 32'd0;
                        ifid_valid_q <= 1'b0;
                    end else if (stall_i) begin
                        // Hold everything; nothing is lost across repeated stalls.
                        pc_q <= pc_q;
                    end else if (is_halt_word_d) begin
                        // The halt word never enters the pipeline.
                        state_q      <= S_HALT;
                        halted_q     <= 1'b1;
                        ifid_instr_q <= 32'd0;
                        ifid_pcp4_q  <= 32'd0;
                        ifid_valid_q <= 1'b0;
                    end else begin
                        ifid_instr_q <= instruction_i;
                        ifid_pcp4_q  <= pc_inc_d;
                        ifid_valid_q <= 1'b1;
                        pc_q         <= pc_inc_d;
                        fetch_cnt_q  <= fetch_cnt_q + 32'd1;
                    end
                end
                S_HALT: begin
                    // Terminal until reset; all other inputs are ignored.
                    halted_q     <= 1'b1;
                    ifid_instr_q <= 32'd0;
                    ifid_pcp4_q  <= 32'd0;
                    ifid_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_address_o    = pc_q;
    assign ifid_instruction_o = ifid_instr_q;
    assign ifid_pcplus4_o     = ifid_pcp4_q;
    assign ifid_valid_o       = ifid_valid_q;
    assign fetch_count_o      = fetch_cnt_q;
    assign halted_o           = halted_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: instruction memory image, spec-level reference
// model, per-cycle compare process and a directed scenario with literal pins.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instruction;
    logic [31:0] instr_address;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pcplus4;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic        halted;
    logic [1:0]  state_dbg;

    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    // reference model: spec-level view of the fetch unit
    int          m_mode;     // 0 idle, 1 running, 2 halted
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic        m_valid;
    logic [31:0] m_count;

    if_stage dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start),
        .stall_i            (stall),
        .flush_i            (flush),
        .branch_taken_i     (branch_taken),
        .branch_target_i    (branch_target),
        .jump_i             (jump),
        .jump_target_i      (jump_target),
        .instruction_i      (instruction),
        .instr_address_o    (instr_address),
        .ifid_instruction_o (ifid_instruction),
        .ifid_pcplus4_o     (ifid_pcplus4),
        .ifid_valid_o       (ifid_valid),
        .fetch_count_o      (fetch_count),
        .halted_o           (halted),
        .state_o            (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational instruction memory, word-indexed by address bits [11:2]
    assign instruction = mem[instr_address[11:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic bubble_model();
        m_instr = 32'd0;
        m_pcp4  = 32'd0;
        m_valid = 1'b0;
    endtask

    // reference model update, one event per active edge or async reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_pc    = 32'd0;
            m_count = 32'd0;
            bubble_model();
        end else if (m_mode == 0) begin
            bubble_model();
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (jump || branch_taken) begin
                m_pc = {(jump ? jump_target[31:2] : branch_target[31:2]), 2'b00};
                bubble_model();
            end else if (flush) begin
                m_pc = m_pc + 32'd4;
                bubble_model();
            end else if (stall) begin
                m_pc = m_pc;
            end else if (mem[m_pc[11:2]] == 32'hFFFF_FFFF) begin
                m_mode = 2;
                bubble_model();
            end else begin
                m_instr = mem[m_pc[11:2]];
                m_pcp4  = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                m_count = m_count + 32'd1;
            end
        end else begin
            bubble_model();
        end
    end

    // scoreboard compare process: every falling edge once enabled
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_pc",     instr_address,          m_pc);
            chk("cyc_instr",  ifid_instruction,       m_instr);
            chk("cyc_pcp4",   ifid_pcplus4,           m_pcp4);
            chk("cyc_valid",  {31'd0, ifid_valid},    {31'd0, m_valid});
            chk("cyc_count",  fetch_count,            m_count);
            chk("cyc_halted", {31'd0, halted},        {31'd0, (m_mode == 2)});
        end
    end

    // driver: advance one active edge, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        start         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump          = 1'b0;
        jump_target   = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i * 3;
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rst_pc",     instr_address, 32'h0);
        chk("rst_valid",  {31'd0, ifid_valid}, 32'd0);
        chk("rst_count",  fetch_count, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // IDLE holds without start
        step();
        chk("idle_pc", instr_address, 32'h0);

        // start: no capture on the transition edge
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_valid", {31'd0, ifid_valid}, 32'd0);
        step();
        chk("run1_instr", ifid_instruction, 32'd0);
        chk("run1_pcp4",  ifid_pcplus4, 32'd4);
        chk("run1_valid", {31'd0, ifid_valid}, 32'd1);
        step();
        chk("run2_instr", ifid_instruction, 32'd3);
        chk("run2_pcp4",  ifid_pcplus4, 32'd8);
        chk("run2_count", fetch_count, 32'd2);

        // three stall cycles at PC=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("stall_pc",    instr_address, 32'd8);
        chk("stall_instr", ifid_instruction, 32'd3);
        chk("stall_count", fetch_count, 32'd2);
        stall = 1'b0;
        step();
        chk("unstall_instr", ifid_instruction, 32'd6);
        chk("unstall_count", fetch_count, 32'd3);

        // branch with simultaneous stall, misaligned target
        branch_taken  = 1'b1;
        branch_target = 32'h43;
        stall         = 1'b1;
        step();
        clear_inputs();
        chk("br_pc",    instr_address, 32'h40);
        chk("br_valid", {31'd0, ifid_valid}, 32'd0);
        step();
        chk("br_instr", ifid_instruction, 32'd48);
        chk("br_pcp4",  ifid_pcplus4, 32'h44);

        // jump has priority over branch
        jump          = 1'b1;
        jump_target   = 32'h100;
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        step();
        clear_inputs();
        chk("jmp_pc", instr_address, 32'h100);
        step();
        chk("jmp_instr", ifid_instruction, 32'd192);

        // flush alone
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_pc",    instr_address, 32'h108);
        chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
        step();
        chk("flush_next", ifid_instruction, 32'd198);

        // PC wrap at the top of the address space
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        chk("wrap_pc", instr_address, 32'hFFFF_FFFC);
        step();
        chk("wrap_instr", ifid_instruction, 32'd3069);
        chk("wrap_pcp4",  ifid_pcplus4, 32'd0);
        chk("wrap_next",  instr_address, 32'd0);

        // halt word at address 20
        mem[5]      = 32'hFFFF_FFFF;
        jump        = 1'b1;
        jump_target = 32'h10;
        step();
        clear_inputs();
        step();
        chk("pre_halt_instr", ifid_instruction, 32'd12);
        stall = 1'b1;
        step();
        stall = 1'b0;
        chk("stalled_halt_word", {31'd0, halted}, 32'd0);
        step();
        chk("halt_flag",  {31'd0, halted}, 32'd1);
        chk("halt_pc",    instr_address, 32'd20);
        chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
        chk("halt_count", fetch_count, 32'd8);
        jump        = 1'b1;
        jump_target = 32'h0;
        flush       = 1'b1;
        start       = 1'b1;
        step();
        step();
        clear_inputs();
        chk("halt_jump_pc", instr_address, 32'd20);
        chk("halt_stays",   {31'd0, halted}, 32'd1);

        // reset out of HALT, restart, then async reset mid-run
        mem[5] = 32'd15;
        rst_n  = 1'b0;
        #1;
        chk("rst_from_halt", {31'd0, halted}, 32'd0);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("rerun_count", fetch_count, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("async_pc",    instr_address, 32'h0);
        chk("async_count", fetch_count, 32'd0);
        chk("async_valid", {31'd0, ifid_valid}, 32'd0);
        chk("async_instr", ifid_instruction, 32'd0);
        chk("async_state", {30'd0, state_dbg}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", instr_address, 32'h0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
